// File: rtl/timer_ctrl.sv
// Countdown timer controller: button-driven set/run/pause FSM that
// steers an external mm:ss digit chain through enable, step and load strobes.
module timer_ctrl #(
   parameter int unsigned TICK_DIV = 50000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_start,
   input  logic        btn_mode,
   input  logic        btn_inc,
   input  logic [3:0]  digit_done,
   output logic        digit_enable,
   output logic        digit_step,
   output logic [3:0]  set_sel,
   output logic [3:0]  set_value,
   output logic [15:0] max_count,
   output logic [2:0]  state,
   output logic        alarm
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [15:0] MAX = {4'd5, 4'd9, 4'd5, 4'd9};

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SET     = 3'd1,
      RUN     = 3'd2,
      PAUSE   = 3'd3,
      EXPIRED = 3'd4
   } state_t;

   state_t          st_q, st_d;
   logic [1:0]      cur_q, cur_d;
   logic [PW-1:0]   pre_q, pre_d;
   logic [3:0][3:0] sh_q, sh_d;
   logic            start_q, mode_q, inc_q;
   logic            rise_start, rise_mode, rise_inc;
   logic            wrap, all_done;
   logic [3:0]      lim;
   logic            en_d, step_d, alarm_d;
   logic [3:0]      sel_d, val_d;

   // start wins a same-cycle tie; the other edges are dropped
   assign rise_start = btn_start & ~start_q;
   assign rise_mode  = btn_mode & ~mode_q & ~rise_start;
   assign rise_inc   = btn_inc & ~inc_q & ~rise_start;

   assign wrap      = (pre_q == PW'(TICK_DIV - 1));
   assign all_done  = (digit_done == 4'hF);
   assign lim       = MAX[{cur_q, 2'b00} +: 4];
   assign max_count = MAX;
   assign state     = st_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q    <= IDLE;
         cur_q   <= '0;
         pre_q   <= '0;
         sh_q    <= '0;
         start_q <= 1'b0;
         mode_q  <= 1'b0;
         inc_q   <= 1'b0;
      end else begin
         st_q    <= st_d;
         cur_q   <= cur_d;
         pre_q   <= pre_d;
         sh_q    <= sh_d;
         start_q <= btn_start;
         mode_q  <= btn_mode;
         inc_q   <= btn_inc;
      end
   end

   always_comb begin
      st_d  = st_q;
      cur_d = cur_q;
      pre_d = pre_q;
      sh_d  = sh_q;
      unique case (st_q)
         IDLE: begin
            if (rise_start) begin
               if (!all_done) begin
                  st_d  = RUN;
                  pre_d = '0;
               end
            end else if (rise_mode) begin
               st_d  = SET;
               cur_d = '0;
            end
         end
         SET: begin
            if (rise_inc) begin
               sh_d[cur_q] = (sh_q[cur_q] == lim) ?
                             4'd0 : sh_q[cur_q] + 4'd1;
            end else if (rise_mode) begin
               if (cur_q == 2'd3) st_d = IDLE;
               else cur_d = cur_q + 2'd1;
            end
         end
         RUN: begin
            if (all_done) begin
               st_d = EXPIRED;
            end else if (rise_start) begin
               st_d = PAUSE;
            end else begin
               pre_d = wrap ? '0 : pre_q + PW'(1);
            end
         end
         PAUSE: begin
            if (rise_start) begin
               st_d = RUN;
            end else if (rise_mode) begin
               st_d  = IDLE;
               pre_d = '0;
            end
         end
         EXPIRED: begin
            if (rise_start || rise_mode) st_d = IDLE;
         end
         default: st_d = IDLE;
      endcase
   end

   // outputs follow the next state so they line up with the state register
   always_comb begin
      en_d    = (st_d == RUN);
      alarm_d = (st_d == EXPIRED);
      step_d  = (st_q == RUN) && (st_d == RUN) && wrap;
      sel_d   = '0;
      val_d   = '0;
      if (st_q == SET && rise_inc) begin
         sel_d = 4'b0001 << cur_q;
         val_d = sh_d[cur_q];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         digit_enable <= 1'b0;
         digit_step   <= 1'b0;
         set_sel      <= '0;
         set_value    <= '0;
         alarm        <= 1'b0;
      end else begin
         digit_enable <= en_d;
         digit_step   <= step_d;
         set_sel      <= sel_d;
         set_value    <= val_d;
         alarm        <= alarm_d;
      end
   end

endmodule
